// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Active scanner for a 4x4 matrix keypad used for clock/alarm time entry.
//   It pulls one column low at a time and reads the active-low rows through a
//   2-flop synchroniser. Press and release are each debounced over
//   DEBOUNCE_SCANS consecutive scan ticks. Each physical press produces
//   exactly one key event.
//
// Ports
//   clk        system clock, all logic on posedge
//   rst        asynchronous reset, active low
//   en         scan enable; low parks the scanner (columns released)
//   row[3:0]   keypad rows, active low, externally pulled up
//   col[3:0]   keypad columns, one-hot active low (4'b1111 while parked)
//   key_valid  one-clk strobe when a debounced press is accepted
//   key_code   code of the last accepted key, held until the next accept
//   key_held   high from accept until the release has been debounced
//
// States
//   SCAN      | rotating columns, looking for any low row
//   DEB_PRESS | column frozen, counting stable-low ticks on the candidate row
//   HELD      | key accepted, waiting for the candidate row to go high
//   DEB_REL   | counting stable-high ticks on the candidate row
module keypad_scanner #(
  parameter int CLK_HZ         = 100_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int              TICK_DIV  = CLK_HZ / SCAN_HZ;
  localparam int              TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [3:0]      DEB_N     = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2,
    DEB_REL   = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    row_s1, row_s2;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [3:0]    cnt, cnt_nxt, cnt_inc;
  logic [1:0]    cand_row, cand_row_nxt;
  logic [1:0]    col_idx, col_idx_nxt;
  logic [1:0]    low_row;
  logic          cand_low;
  logic [3:0]    code_nxt;
  logic          valid_nxt;
  logic          held_nxt;

  function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
    logic [3:0] code;
    case ({c, r})
      4'b00_00: code = 4'd1;
      4'b00_01: code = 4'd4;
      4'b00_10: code = 4'd7;
      4'b00_11: code = 4'd14;
      4'b01_00: code = 4'd2;
      4'b01_01: code = 4'd5;
      4'b01_10: code = 4'd8;
      4'b01_11: code = 4'd0;
      4'b10_00: code = 4'd3;
      4'b10_01: code = 4'd6;
      4'b10_10: code = 4'd9;
      4'b10_11: code = 4'd15;
      4'b11_00: code = 4'd10;
      4'b11_01: code = 4'd11;
      4'b11_10: code = 4'd12;
      4'b11_11: code = 4'd13;
      default:  code = 4'd0;
    endcase
    return code;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
    end
  end

  // Held at zero while parked so a re-enable always starts a full dwell.
  assign tick = en && (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      tick_cnt <= '0;
    else if (!en || tick)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + TW'(1);
  end

  // Lowest low row index wins when several rows are low together.
  always_comb begin
    low_row = 2'd3;
    if (!row_s2[2]) low_row = 2'd2;
    if (!row_s2[1]) low_row = 2'd1;
    if (!row_s2[0]) low_row = 2'd0;
  end

  assign cand_low = ~row_s2[cand_row];
  assign cnt_inc  = cnt + 4'd1;
  assign col      = en ? ~(4'b0001 << col_idx) : 4'b1111;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    cand_row_nxt = cand_row;
    col_idx_nxt  = col_idx;
    code_nxt     = key_code;
    valid_nxt    = 1'b0;
    held_nxt     = key_held;
    if (!en) begin
      state_nxt   = SCAN;
      cnt_nxt     = '0;
      col_idx_nxt = '0;
      held_nxt    = 1'b0;
    end else if (tick) begin
      case (state)
        SCAN: begin
          if (row_s2 != 4'hF) begin
            cand_row_nxt = low_row;
            if (DEB_N == 4'd1) begin
              code_nxt  = key_map(col_idx, low_row);
              valid_nxt = 1'b1;
              held_nxt  = 1'b1;
              cnt_nxt   = '0;
              state_nxt = HELD;
            end else begin
              cnt_nxt   = 4'd1;
              state_nxt = DEB_PRESS;
            end
          end else begin
            col_idx_nxt = col_idx + 2'd1;
          end
        end
        DEB_PRESS: begin
          if (cand_low) begin
            if (cnt_inc == DEB_N) begin
              code_nxt  = key_map(col_idx, cand_row);
              valid_nxt = 1'b1;
              held_nxt  = 1'b1;
              cnt_nxt   = '0;
              state_nxt = HELD;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else begin
            // Bounce: give up on this column and keep rotating.
            cnt_nxt     = '0;
            col_idx_nxt = col_idx + 2'd1;
            state_nxt   = SCAN;
          end
        end
        HELD: begin
          if (!cand_low) begin
            if (DEB_N == 4'd1) begin
              held_nxt    = 1'b0;
              cnt_nxt     = '0;
              col_idx_nxt = col_idx + 2'd1;
              state_nxt   = SCAN;
            end else begin
              cnt_nxt   = 4'd1;
              state_nxt = DEB_REL;
            end
          end
        end
        DEB_REL: begin
          if (!cand_low) begin
            if (cnt_inc == DEB_N) begin
              held_nxt    = 1'b0;
              cnt_nxt     = '0;
              col_idx_nxt = col_idx + 2'd1;
              state_nxt   = SCAN;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else begin
            cnt_nxt   = '0;
            state_nxt = HELD;
          end
        end
        default: state_nxt = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SCAN;
      cnt       <= '0;
      cand_row  <= '0;
      col_idx   <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cand_row  <= cand_row_nxt;
      col_idx   <= col_idx_nxt;
      key_code  <= code_nxt;
      key_valid <= valid_nxt;
      key_held  <= held_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Bench for keypad_scanner: a physical keypad model (pressed-key matrix
//   resolved against the driven columns), a behavioural reference model
//   compared against the DUT every cycle, directed scenarios with literal
//   expectations, and a randomized key/enable soak.
module tb_keypad_scanner;

  localparam int CLK_HZ  = 1000;
  localparam int SCAN_HZ = 250;
  localparam int DEB     = 3;
  localparam int TDIV    = CLK_HZ / SCAN_HZ;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  // Physical keys, bit index = r*4 + c.
  logic [15:0] pressed = '0;

  int checks = 0;
  int errors = 0;
  int ev_count = 0;
  logic [3:0] last_code = '0;

  keypad_scanner #(
    .CLK_HZ(CLK_HZ),
    .SCAN_HZ(SCAN_HZ),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .row(row),
    .col(col),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_held(key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && (col[c] === 1'b0)) row[r] = 1'b0;
  end

  // ---------------- reference model ----------------
  // Physical keypad layout read row by row.
  int keymap[16] = '{1, 2, 3, 10,
                     4, 5, 6, 11,
                     7, 8, 9, 12,
                     14, 0, 15, 13};

  int         m_tcnt = 0;
  int         m_col = 0;
  int         m_cand = 0;
  int         m_streak = 0;
  bit         m_engaged = 0;
  bit         m_held = 0;
  logic [3:0] m_s1 = 4'hF;
  logic [3:0] m_s2 = 4'hF;
  logic       m_valid = 1'b0;
  logic [3:0] m_code = '0;

  task automatic model_reset();
    m_tcnt = 0; m_col = 0; m_cand = 0; m_streak = 0;
    m_engaged = 0; m_held = 0;
    m_s1 = 4'hF; m_s2 = 4'hF;
    m_valid = 1'b0; m_code = '0;
  endtask

  task automatic model_accept();
    m_code   = 4'(keymap[m_cand*4 + m_col]);
    m_valid  = 1'b1;
    m_held   = 1;
    m_streak = 0;
  endtask

  task automatic model_step();
    logic [3:0] s;
    bit tick;
    s    = m_s2;
    m_s2 = m_s1;
    m_s1 = row;
    tick   = en && (m_tcnt == TDIV - 1);
    m_tcnt = en ? (m_tcnt + 1) % TDIV : 0;
    m_valid = 1'b0;
    if (!en) begin
      m_col = 0; m_engaged = 0; m_held = 0; m_streak = 0;
    end else if (tick) begin
      if (!m_engaged) begin
        if (s != 4'hF) begin
          m_cand = 0;
          while (s[m_cand]) m_cand++;
          m_engaged = 1;
          m_streak  = 1;
          if (m_streak >= DEB) model_accept();
        end else begin
          m_col = (m_col + 1) % 4;
        end
      end else if (!m_held) begin
        if (!s[m_cand]) begin
          m_streak++;
          if (m_streak >= DEB) model_accept();
        end else begin
          m_engaged = 0; m_streak = 0; m_col = (m_col + 1) % 4;
        end
      end else begin
        if (s[m_cand]) begin
          m_streak++;
          if (m_streak >= DEB) begin
            m_held = 0; m_engaged = 0; m_streak = 0; m_col = (m_col + 1) % 4;
          end
        end else begin
          m_streak = 0;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else      model_step();
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s t=%0t got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Per-cycle comparison against the model, plus event bookkeeping.
  initial begin
    logic [3:0] exp_col;
    forever begin
      @(negedge clk);
      exp_col = 4'hF;
      if (en) exp_col[m_col] = 1'b0;
      chk("col", {28'd0, col}, {28'd0, exp_col});
      chk("key_valid", {31'd0, key_valid}, {31'd0, m_valid});
      chk("key_code", {28'd0, key_code}, {28'd0, m_code});
      chk("key_held", {31'd0, key_held}, {31'd0, m_held});
      if (key_valid === 1'b1) begin
        ev_count++;
        last_code = key_code;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic reset_outputs_check(input string tag);
    chk({tag, "_col"}, {28'd0, col}, 32'hE);
    chk({tag, "_valid"}, {31'd0, key_valid}, 32'd0);
    chk({tag, "_code"}, {28'd0, key_code}, 32'd0);
    chk({tag, "_held"}, {31'd0, key_held}, 32'd0);
  endtask

  initial begin
    int base;
    int n;
    logic [3:0] e;
    int sel;

    // Reset and idle rotation
    en = 1'b1;
    #1 rst = 1'b0;
    #2 reset_outputs_check("reset");
    @(posedge clk); #2;
    rst = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      e = 4'hF;
      e[(i / 4) % 4] = 1'b0;
      chk("idle_rotation", {28'd0, col}, {28'd0, e});
    end
    @(posedge clk); #2;
    chk("idle_no_event", ev_count, 0);

    // Clean press of "0" (c1 r3)
    base = ev_count;
    pressed[13] = 1'b1;
    step(40);
    chk("zero_events", ev_count - base, 1);
    chk("zero_code", {28'd0, last_code}, 32'd0);
    chk("zero_held", {31'd0, key_held}, 32'd1);
    chk("zero_col_frozen", {28'd0, col}, 32'hD);
    pressed = '0;
    step(30);
    chk("zero_released", {31'd0, key_held}, 32'd0);
    chk("zero_single_event", ev_count - base, 1);

    // Bouncy press of "B" (c3 r1)
    base = ev_count;
    pressed[7] = 1'b1; step(4);
    pressed[7] = 1'b0; step(4);
    pressed[7] = 1'b1; step(60);
    chk("b_events", ev_count - base, 1);
    chk("b_code", {28'd0, last_code}, 32'd11);
    pressed = '0;
    step(40);

    // "1" held, then "3" pressed during HELD
    base = ev_count;
    pressed[0] = 1'b1;
    step(40);
    chk("one_events", ev_count - base, 1);
    chk("one_code", {28'd0, last_code}, 32'd1);
    pressed[2] = 1'b1;
    step(30);
    chk("three_ignored", ev_count - base, 1);
    pressed[0] = 1'b0;
    step(60);
    chk("three_events", ev_count - base, 2);
    chk("three_code", {28'd0, last_code}, 32'd3);
    pressed = '0;
    step(40);

    // "#" (c2 r3) interrupted by en=0, then re-enabled with key held
    base = ev_count;
    pressed[14] = 1'b1;
    n = 0;
    while (col !== 4'b1011 && n < 64) begin step(1); n++; end
    chk("hash_col2_reached", {31'd0, n < 64}, 32'd1);
    step(8);
    en = 1'b0;
    step(4);
    chk("park_col", {28'd0, col}, 32'hF);
    chk("park_code_kept", {28'd0, key_code}, 32'd3);
    chk("park_held", {31'd0, key_held}, 32'd0);
    chk("park_no_event", ev_count - base, 0);
    en = 1'b1;
    step(40);
    chk("hash_events", ev_count - base, 1);
    chk("hash_code", {28'd0, last_code}, 32'd15);
    pressed = '0;
    step(40);

    // Async reset while "5" (c1 r1) is held
    pressed[5] = 1'b1;
    n = 0;
    while (key_held !== 1'b1 && n < 80) begin step(1); n++; end
    chk("five_held_reached", {31'd0, n < 80}, 32'd1);
    rst = 1'b0;
    #1 reset_outputs_check("async_reset");
    base = ev_count;
    step(3);
    rst = 1'b1;
    step(60);
    chk("five_redebounced", ev_count - base, 1);
    chk("five_code", {28'd0, last_code}, 32'd5);
    pressed = '0;
    step(30);

    // Randomized soak against the model
    for (int k = 0; k < 300; k++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 3)
        pressed = '0;
      else if (sel <= 7)
        pressed = 16'(1) << $urandom_range(0, 15);
      else if (sel == 8)
        pressed = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      else
        en = ~en;
      step($urandom_range(2, 40));
    end
    en = 1'b1;
    pressed = '0;
    step(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
